sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Conditions raw slide-switch inputs before they drive the switch-to-LED stage.
//  - Synchronises each asynchronous switch bit into the clk domain.
//  - Debounces each bit independently and emits a stable switch vector.
//  - Emits single-cycle rise/fall pulses for each bit.
//  sw_db connects directly to the sw input of the downstream LED stage.
// PARAMETERS
//  WIDTH            8      number of switch bits
//  DEBOUNCE_CYCLES  50000  consecutive stable synced cycles before a bit commits; must be >= 1
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  per-bit counter width (derived, localparam)
// PORTS
//  clk        in   1      system clock; all state changes on the rising edge
//  rst_n      in   1      synchronous active-low reset
//  sw_raw     in   WIDTH  asynchronous switch pins
//  sw_db      out  WIDTH  debounced, registered switch state
//  sw_rise    out  WIDTH  1-cycle pulse per bit on a committed 0->1 change
//  sw_fall    out  WIDTH  1-cycle pulse per bit on a committed 1->0 change
//  sw_changed out  1      registered OR of (sw_rise | sw_fall)
// BEHAVIOUR
//  - Reset: one clock and reset; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//    While rst_n=0 at an edge, all of the following are 0: sync stages, counters, sw_db, sw_rise,
//    sw_fall, sw_changed.
//  - Sync: two flops per bit, sync1 <= sw_raw and sync2 <= sync1. There is no reset bypass.
//  - Per-bit state: cnt[CNT_W], stable (= sw_db bit). Each edge, with mismatch = sync2 ^ stable:
//    - mismatch=0: cnt <= 0. A glitch shorter than the window is discarded.
//    - mismatch=1, cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//    - mismatch=1, cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
//      On the same edge, rise <= sync2 and fall <= ~sync2.
//  - Pulses:
//    - rise/fall are 1 for exactly one cycle, aligned with the cycle in which sw_db first shows the new value.
//    - Otherwise both are 0; rise & fall is never 1 for the same bit.
//  - sw_changed is registered from the next-state pulses, so it is cycle-aligned with sw_rise/sw_fall.
//  - Latency: if sw_raw is stable from before edge E1, sw_db updates on edge E(DEBOUNCE_CYCLES+2).
//    With DEBOUNCE_CYCLES=1 that is 3 edges.
//  - Counter never wraps: it is bounded by the commit compare and cleared on commit or match.
//  - Bounce: any return to the committed value restarts the count from 0. The window is not cumulative.
//  - Bits are fully independent; several bits may commit on the same edge.
//  - Reset mid-count: the count is lost and sw_db returns to 0.
//    A switch held high through reset commits 1, with a rise pulse, DEBOUNCE_CYCLES+2 edges after rst_n=1.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Package sw_pkg:
//    - SW_WIDTH = 8, shared with the LED stage.
//    - typedef logic [SW_WIDTH-1:0] sw_vec_t.
//    - DEBOUNCE_CYCLES_DEFAULT = 50000 (1 ms at 50 MHz).
//  - Sub-module sw_debounce_bit:
//    - Contains the synchroniser, counter, stable flop and rise/fall flops for one bit.
//    - Instantiated WIDTH times with a generate loop.
//  - Top level: the generate loop and the sw_changed OR/register.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=8)
//  1. rst_n=0 for 3 cycles with sw_raw=8'hFF -> all outputs 0 at every edge.
//     Release rst_n with sw_raw still 8'hFF -> sw_db=8'hFF on edge 6, sw_rise=8'hFF for 1 cycle, sw_changed=1 for 1 cycle.
//  2. From sw_db=8'h00, sw_raw[3] 0->1 clean -> sw_db=8'h08 exactly 6 edges later; sw_rise=8'h08 one cycle; no other pulses.
//  3. Bounce: sw_raw[0] toggles 1,0,1,0,1 at 1-cycle spacing, then holds 1 ->
//     sw_db[0] stays 0 during the bounce and commits 6 edges after the final hold begins; only one rise pulse.
//  4. 3-cycle glitch on sw_raw[7] (< window) -> sw_db, sw_rise and sw_fall never change.
//  5. sw_raw 8'h0F -> 8'hF0 in one cycle with sw_db=8'h0F ->
//     same edge: sw_db=8'hF0, sw_rise=8'hF0, sw_fall=8'h0F, sw_changed=1 for 1 cycle.
//  6. rst_n pulsed low for 1 cycle at cnt=2 mid-debounce of bit 2 (sw_raw=8'h04) ->
//     outputs cleared; bit 2 recommits 6 edges after release with a rise pulse.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared switch-path types and defaults, also used by the LED stage.
package sw_pkg;
  localparam int SW_WIDTH                = 8;
  // 1 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;
endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced vector and edge pulses out.
interface sw_debounce_if
  import sw_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  // Debouncer side
  modport slave  (input  sw_raw, output sw_db, sw_rise, sw_fall, sw_changed);
  // Pin / consumer side
  modport master (output sw_raw, input  sw_db, sw_rise, sw_fall, sw_changed);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, consecutive-mismatch counter,
// committed (stable) flop and registered rise/fall pulses.
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic pulse_d_o   // next-state rise|fall, for the top-level changed flag
);
  localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             mismatch;

  assign mismatch = sync2_q ^ stable_q;

  // Count consecutive disagreeing synced cycles; commit when the window fills.
  // Any agreement restarts the window, so bounces never accumulate.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter, committed value and pulse registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign db_o      = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pulse_d_o = rise_d | fall_d;
endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit debounce plus a registered any-change flag.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);
  logic [WIDTH-1:0] db_w, rise_w, fall_w, pulse_d_w;
  logic             sw_changed_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .raw_i     (bus.sw_raw[g]),
      .db_o      (db_w[g]),
      .rise_o    (rise_w[g]),
      .fall_o    (fall_w[g]),
      .pulse_d_o (pulse_d_w[g])
    );
  end

  // Registered from next-state pulses so it lines up with sw_rise/sw_fall.
  always_ff @(posedge clk) begin
    if (!rst_n) sw_changed_q <= 1'b0;
    else        sw_changed_q <= |pulse_d_w;
  end

  assign bus.sw_db      = db_w;
  assign bus.sw_rise    = rise_w;
  assign bus.sw_fall    = fall_w;
  assign bus.sw_changed = sw_changed_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: run-length model checked every cycle plus
// hand-computed expectations at the key edges of each scenario.
module tb_sw_debounce;
  localparam int W  = 8;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: a bit's input is seen two edges late; once it has disagreed with
  // the committed value for DC consecutive edges, it commits with a pulse.
  logic [W-1:0] m_d1 = '0, m_d2 = '0;
  logic [W-1:0] m_db = '0, m_rise = '0, m_fall = '0;
  logic         m_chg = 1'b0;
  int           m_run [W];
  logic         m_started = 1'b0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int b = 0; b < W; b++) begin
        if (m_d2[b] != m_db[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DC) begin
            m_db[b]   = m_d2[b];
            m_rise[b] = m_d2[b];
            m_fall[b] = ~m_d2[b];
            m_run[b]  = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_chg = |(m_rise | m_fall);
      m_d2  = m_d1;
      m_d1  = bus.sw_raw;
    end
  end

  // Literal expectations posted by the stimulus for the next edge.
  logic         lit_vld = 1'b0;
  logic [W-1:0] lit_db, lit_rise, lit_fall;
  logic         lit_chg;

  int n_cmp = 0;
  int n_bad = 0;

  // Single compare process, 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (m_started) begin
      n_cmp++;
      if (bus.sw_db !== m_db || bus.sw_rise !== m_rise ||
          bus.sw_fall !== m_fall || bus.sw_changed !== m_chg) begin
        n_bad++;
        $display("FAIL model t=%0t db=%h/%h rise=%h/%h fall=%h/%h chg=%b/%b (got/required)",
                 $time, bus.sw_db, m_db, bus.sw_rise, m_rise, bus.sw_fall, m_fall,
                 bus.sw_changed, m_chg);
      end
    end
    if (lit_vld) begin
      n_cmp++;
      if (bus.sw_db !== lit_db || bus.sw_rise !== lit_rise ||
          bus.sw_fall !== lit_fall || bus.sw_changed !== lit_chg) begin
        n_bad++;
        $display("FAIL literal t=%0t db=%h/%h rise=%h/%h fall=%h/%h chg=%b/%b (got/required)",
                 $time, bus.sw_db, lit_db, bus.sw_rise, lit_rise, bus.sw_fall, lit_fall,
                 bus.sw_changed, lit_chg);
      end
    end
  end

  // Expect given outputs after the n-th rising edge from now (called at a falling edge or t=0).
  task automatic expect_at(input int n, input logic [W-1:0] db, input logic [W-1:0] rise,
                           input logic [W-1:0] fall, input logic chg);
    repeat (n - 1) @(negedge clk);
    lit_db = db; lit_rise = rise; lit_fall = fall; lit_chg = chg;
    lit_vld = 1'b1;
    @(negedge clk);
    lit_vld = 1'b0;
  endtask

  initial begin
    // 1: reset held with all switches high, then release
    rst_n = 1'b0;
    bus.sw_raw = 8'hFF;
    repeat (3) expect_at(1, 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    expect_at(5, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(1, 8'hFF, 8'hFF, 8'h00, 1'b1);
    expect_at(1, 8'hFF, 8'h00, 8'h00, 1'b0);

    // back to all-off
    bus.sw_raw = 8'h00;
    expect_at(6, 8'h00, 8'h00, 8'hFF, 1'b1);

    // 2: clean rise on bit 3
    bus.sw_raw = 8'h08;
    expect_at(5, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(1, 8'h08, 8'h08, 8'h00, 1'b1);
    expect_at(1, 8'h08, 8'h00, 8'h00, 1'b0);

    // 3: bounce on bit 0, then hold high
    bus.sw_raw = 8'h09; @(negedge clk);
    bus.sw_raw = 8'h08; @(negedge clk);
    bus.sw_raw = 8'h09; @(negedge clk);
    bus.sw_raw = 8'h08; @(negedge clk);
    bus.sw_raw = 8'h09;
    expect_at(5, 8'h08, 8'h00, 8'h00, 1'b0);
    expect_at(1, 8'h09, 8'h01, 8'h00, 1'b1);

    // 4: 3-cycle glitch on bit 7 is discarded
    bus.sw_raw = 8'h89;
    repeat (3) @(negedge clk);
    bus.sw_raw = 8'h09;
    expect_at(10, 8'h09, 8'h00, 8'h00, 1'b0);

    // 5: simultaneous commit of opposite edges
    bus.sw_raw = 8'h0F;
    repeat (8) @(negedge clk);
    expect_at(1, 8'h0F, 8'h00, 8'h00, 1'b0);
    bus.sw_raw = 8'hF0;
    expect_at(5, 8'h0F, 8'h00, 8'h00, 1'b0);
    expect_at(1, 8'hF0, 8'hF0, 8'h0F, 1'b1);
    expect_at(1, 8'hF0, 8'h00, 8'h00, 1'b0);

    // 6: reset pulse mid-count on bit 2
    bus.sw_raw = 8'h00;
    repeat (8) @(negedge clk);
    bus.sw_raw = 8'h04;
    repeat (4) @(negedge clk);   // bit 2 count now 2
    rst_n = 1'b0;
    expect_at(1, 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    expect_at(5, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_at(1, 8'h04, 8'h04, 8'h00, 1'b1);
    expect_at(1, 8'h04, 8'h00, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
